// File: rtl/clk_edge_gen_pkg.sv
// Shared definitions for the multi-channel derived-clock generator.
//   CNT_W_DEFAULT : default width of the half-period counter / divisor field
//   eff_half()    : maps a programmed half-period to the one actually used (0 -> 1)
package clk_edge_gen_pkg;

    localparam int unsigned CNT_W_DEFAULT = 10;

    // A half-period of zero cycles is meaningless; treat it as the fastest rate.
    function automatic logic [31:0] eff_half(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/clk_edge_gen_multi_if.sv
// Control/status bundle of the derived-clock generator.
//   enable_clk            per-channel count enable
//   restart               synchronous restart of all channels
//   div_half              packed half-periods, channel i at [i*CNT_W +: CNT_W]
//   new_clk               derived clocks
//   rising_edge           1-cycle pulse in the first high cycle of new_clk
//   falling_edge          1-cycle pulse in the first low cycle of new_clk
//   middle_of_high_level  1-cycle pulse at mid high phase
//   middle_of_low_level   1-cycle pulse at mid low phase
// master drives the controls and observes the clocks; slave is the generator.
interface clk_edge_gen_multi_if
    import clk_edge_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
);
    logic [NUM_CH-1:0]       enable_clk;
    logic                    restart;
    logic [NUM_CH*CNT_W-1:0] div_half;
    logic [NUM_CH-1:0]       new_clk;
    logic [NUM_CH-1:0]       rising_edge;
    logic [NUM_CH-1:0]       falling_edge;
    logic [NUM_CH-1:0]       middle_of_high_level;
    logic [NUM_CH-1:0]       middle_of_low_level;

    modport master (
        output enable_clk, restart, div_half,
        input  new_clk, rising_edge, falling_edge, middle_of_high_level, middle_of_low_level
    );

    modport slave (
        input  enable_clk, restart, div_half,
        output new_clk, rising_edge, falling_edge, middle_of_high_level, middle_of_low_level
    );
endinterface

// File: rtl/clk_edge_gen_ch.sv
// One derived-clock channel: half-period counter, phase, divisor shadow and strobes.
//   clk, reset            system clock, async active-low reset
//   enable                count enable; low holds cnt/phase and re-arms the divisor load
//   restart               forces phase low and re-arms the load (wins over enable)
//   div_half              programmed half-period in clk cycles
//   new_clk               derived 50%-duty clock
//   rising_edge/falling_edge, middle_of_high_level/middle_of_low_level  1-cycle strobes
// Every output is a flop; strobes are computed from the next state so they line up with
// the cycle in which new_clk shows the corresponding level.
module clk_edge_gen_ch
    import clk_edge_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [CNT_W-1:0] div_half,
    output logic             new_clk,
    output logic             rising_edge,
    output logic             falling_edge,
    output logic             middle_of_high_level,
    output logic             middle_of_low_level
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] half_in;
    logic             phase_q, phase_d;
    logic             load_pend_q, load_pend_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mid_high_q, mid_high_d;
    logic             mid_low_q, mid_low_d;

    assign half_in = CNT_W'(eff_half(32'(div_half)));

    always_comb begin
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        shadow_d    = shadow_q;
        load_pend_d = load_pend_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        mid_high_d  = 1'b0;
        mid_low_d   = 1'b0;

        if (restart) begin
            // Forced low without a falling strobe; divisor re-read on the next enabled cycle.
            cnt_d       = '0;
            phase_d     = 1'b0;
            load_pend_d = 1'b1;
        end else if (!enable) begin
            load_pend_d = 1'b1;
        end else if (load_pend_q) begin
            shadow_d    = half_in;
            cnt_d       = '0;
            load_pend_d = 1'b0;
        end else begin
            if (cnt_q == shadow_q - CNT_W'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
                rise_d  = ~phase_q;
                fall_d  = phase_q;
                // Divisor only changes at the start of a low phase, so no runt pulses.
                if (phase_q) begin
                    shadow_d = half_in;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Mid strobes only follow a counting step, never a load.
            mid_high_d = phase_d && (cnt_d == (shadow_d >> 1));
            mid_low_d  = !phase_d && (cnt_d == (shadow_d >> 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            shadow_q    <= CNT_W'(1);
            phase_q     <= 1'b0;
            load_pend_q <= 1'b1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            mid_high_q  <= 1'b0;
            mid_low_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            phase_q     <= phase_d;
            load_pend_q <= load_pend_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            mid_high_q  <= mid_high_d;
            mid_low_q   <= mid_low_d;
        end
    end

    assign new_clk              = phase_q;
    assign rising_edge          = rise_q;
    assign falling_edge         = fall_q;
    assign middle_of_high_level = mid_high_q;
    assign middle_of_low_level  = mid_low_q;

endmodule

// File: rtl/clk_edge_gen_multi.sv
// Multi-channel derived-clock generator: NUM_CH independent clk_edge_gen_ch instances
// sharing clk, reset and restart.
//   clk    system clock (posedge)
//   reset  asynchronous active-low reset
//   bus    slave side of clk_edge_gen_multi_if (controls in, derived clocks/strobes out)
module clk_edge_gen_multi
    import clk_edge_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    clk_edge_gen_multi_if.slave  bus
);

    logic [NUM_CH-1:0] new_clk_w;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] fall_w;
    logic [NUM_CH-1:0] mid_high_w;
    logic [NUM_CH-1:0] mid_low_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_edge_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk                  (clk),
            .reset                (reset),
            .enable               (bus.enable_clk[i]),
            .restart              (bus.restart),
            .div_half             (bus.div_half[i*CNT_W +: CNT_W]),
            .new_clk              (new_clk_w[i]),
            .rising_edge          (rise_w[i]),
            .falling_edge         (fall_w[i]),
            .middle_of_high_level (mid_high_w[i]),
            .middle_of_low_level  (mid_low_w[i])
        );
    end

    assign bus.new_clk              = new_clk_w;
    assign bus.rising_edge          = rise_w;
    assign bus.falling_edge         = fall_w;
    assign bus.middle_of_high_level = mid_high_w;
    assign bus.middle_of_low_level  = mid_low_w;

endmodule
